tag_nios_system_sys_pll_reset_ctrl: RTL and testbench
=====================================================

# tag_nios_system_sys_pll_reset_ctrl

Reset and lock supervisor for the system/SDRAM PLL. Drives the PLL's active-high reset, watches its asynchronous `locked` output, retries on lock timeout, and releases the downstream system reset only after lock has stayed stable for a programmable window. It sits between the board reset/reference clock and the Nios system reset tree. It is the controlling end of the PLL's `rst`/`locked` interface.

## Interface
- `RST_PULSE_CYCLES`, default 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 50000: cycle window per attempt for lock to appear (1 ms at 50 MHz; ≥1).
- `LOCK_STABLE_CYCLES`, default 1024: consecutive locked cycles required before release (≥1).
- `MAX_RETRIES`, default 7: timeouts tolerated before FAIL (0–255).
- `SYNC_STAGES`, default 2: flop stages on `pll_locked` (≥2).
- `clk`  in  1  free-running 50 MHz reference clock, the same clock fed to the PLL `refclk`.
- `reset_n`  in  1  Reset, asynchronous assert, active-low.
- `pll_locked`  in  1  PLL lock, asynchronous to `clk`.
- `pll_rst`  out  1  PLL reset, active-high.
- `sys_reset_n`  out  1  downstream reset, active-low.
- `fail`  out  1  sticky; PLL never locked within the allowed retries.
- `state`  out  3  RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4.
- `retry_count`  out  8  timeouts in the current lock sequence.
- `lock_loss_count`  out  8  lock losses while in RUN, saturating at 255.

## Operation
- `pll_locked` passes through a SYNC_STAGES flop chain to give `locked_s`. All decisions use `locked_s` only.
- RESET_PLL: `pll_rst`=1 and `sys_reset_n`=0. The pulse counter runs 0..RST_PULSE_CYCLES-1, then the block moves to WAIT_LOCK, clearing the timeout counter.
- WAIT_LOCK: `pll_rst`=0.
  - `locked_s`=1 → STABILIZE, stable counter=0.
  - Otherwise the timeout counter increments.
  - At count LOCK_TIMEOUT_CYCLES-1 with `locked_s`=0:
    - if `retry_count`==MAX_RETRIES → FAIL;
    - else `retry_count`+1 → RESET_PLL.
- STABILIZE: the stable counter increments each cycle `locked_s`=1.
  - `locked_s`=0 → WAIT_LOCK. The timeout counter keeps its value and is not cleared, which bounds flaky lock. `retry_count` is unchanged.
  - At stable count LOCK_STABLE_CYCLES-1 with `locked_s`=1 → RUN, and `retry_count` clears to 0.
- RUN: `sys_reset_n`=1. `locked_s`=0 → RESET_PLL, `sys_reset_n`=0, and `lock_loss_count`+1 (saturating).
- FAIL: `pll_rst`=1, `sys_reset_n`=0, `fail`=1. The only exit is `reset_n`.
- Counter widths are $clog2(param+1). Comparisons are exact-equality against param-1.

## Timing
- Reset values: `pll_rst`=1, `sys_reset_n`=0, `fail`=0, `state`=0, `retry_count`=0, `lock_loss_count`=0, sync chain=0.
- `reset_n` low forces these values immediately, in any state and mid-count.
- All outputs are registered and change on the same edge as the state transition. There is no combinational path from `pll_locked`.
- After `reset_n` rises, `pll_rst` stays high for exactly RST_PULSE_CYCLES edges.
- Lock release latency from the first edge sampling `pll_locked`=1: SYNC_STAGES edges to `locked_s`, then +1 edge to STABILIZE, then +LOCK_STABLE_CYCLES edges until `sys_reset_n`=1.
- Lock-loss latency from the first edge sampling `pll_locked`=0 in RUN: `sys_reset_n`=0 after SYNC_STAGES+1 edges.
- A `pll_locked` glitch shorter than one `clk` period may be missed; this is acceptable.
- Simultaneous events: in WAIT_LOCK, `locked_s`=1 on the timeout edge → STABILIZE wins. In STABILIZE, a drop on the final stable count → WAIT_LOCK wins.
- Total lock attempts before FAIL = MAX_RETRIES+1.

## Test plan
Parameters for all scenarios: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- Clean bring-up: release `reset_n`, raise `pll_locked` 10 cycles later → `pll_rst` high for exactly 4 cycles; `sys_reset_n` rises 11 edges after `pll_locked` is first sampled high; `state`=3, `retry_count`=0.
- Retry then lock: hold `pll_locked`=0 for one full timeout, then raise it → one extra 4-cycle `pll_rst` pulse, `retry_count`=1 while locking; it clears to 0 on entering RUN.
- Never locks: keep `pll_locked`=0 → three `pll_rst` pulses, then `state`=4, `fail`=1, `pll_rst`=1, `sys_reset_n`=0 held for 200 cycles. `reset_n` pulse → all reset values restored.
- Flaky stabilize: drop `pll_locked` for 3 cycles at stable count 5 → back to WAIT_LOCK, no `pll_rst` pulse; re-lock → RUN 8 cycles after re-entering STABILIZE.
- Loss in RUN: drop `pll_locked` → `sys_reset_n`=0 3 edges later, `lock_loss_count`=1, new 4-cycle `pll_rst` pulse. Force 260 losses → count stays at 255.
- Async reset mid-STABILIZE: assert `reset_n` between edges → outputs take reset values without waiting for a clock edge.

Source files
------------

// File: rtl/tag_nios_system_sys_pll_reset_ctrl.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable lock with
// bounded retries, and only then releases the downstream system reset.
module tag_nios_system_sys_pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int PULSE_W   = $clog2(RST_PULSE_CYCLES + 1);
  localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [PULSE_W-1:0]   PULSE_LAST   = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]           RETRY_LIMIT  = 8'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t                 state_q, state_d;
  logic [PULSE_W-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [TIMEOUT_W-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic [STABLE_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic [7:0]             retry_q, retry_d;
  logic [7:0]             loss_q, loss_d;

  // pll_locked is asynchronous to clk; only the last stage is ever looked at.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its neighbour, which is what turns this into a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_RESET_PLL;
      pulse_cnt_q     <= '0;
      timeout_cnt_q   <= '0;
      stable_cnt_q    <= '0;
      retry_q         <= '0;
      loss_q          <= '0;
      pll_rst         <= 1'b1;
      sys_reset_n     <= 1'b0;
      fail            <= 1'b0;
    end else begin
      state_q         <= state_d;
      pulse_cnt_q     <= pulse_cnt_d;
      timeout_cnt_q   <= timeout_cnt_d;
      stable_cnt_q    <= stable_cnt_d;
      retry_q         <= retry_d;
      loss_q          <= loss_d;
      // Outputs are decoded from the next state so they flip on the same edge
      // as the transition while still coming straight out of flops.
      pll_rst         <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
      sys_reset_n     <= (state_d == ST_RUN);
      fail            <= (state_d == ST_FAIL);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    pulse_cnt_d   = pulse_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    retry_d       = retry_q;
    loss_d        = loss_q;

    unique case (state_q)
      ST_RESET_PLL: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d       = ST_WAIT_LOCK;
          timeout_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        // A lock seen on the timeout edge takes priority over the retry.
        if (locked_s) begin
          state_d      = ST_STABILIZE;
          stable_cnt_d = '0;
        end else if (timeout_cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            retry_d     = retry_q + 8'd1;
            state_d     = ST_RESET_PLL;
            pulse_cnt_d = '0;
          end
        end else begin
          timeout_cnt_d = timeout_cnt_q + TIMEOUT_W'(1);
        end
      end

      ST_STABILIZE: begin
        // The timeout counter is deliberately left running across a dropout so
        // a PLL that keeps flickering still runs out its attempt window.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (stable_cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + STABLE_W'(1);
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          state_d     = ST_RESET_PLL;
          pulse_cnt_d = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        state_d     = ST_RESET_PLL;
        pulse_cnt_d = '0;
      end
    endcase
  end

  assign state           = state_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_tag_nios_system_sys_pll_reset_ctrl.sv
// Bench for the PLL reset supervisor: directed scenarios plus random lock
// traffic, all checked cycle by cycle against a behavioural model scoreboard.
module tb_tag_nios_system_sys_pll_reset_ctrl;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int LS = 8;
  localparam int MR = 2;
  localparam int SS = 2;

  localparam int C_RST_LOW  = 0;
  localparam int C_RST_HIGH = 1;
  localparam int C_SRN_HIGH = 2;
  localparam int C_SRN_LOW  = 3;
  localparam int C_STAB     = 4;
  localparam int C_FAIL     = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       fail;
  logic [2:0] state;
  logic [7:0] retry_count;
  logic [7:0] lock_loss_count;

  tag_nios_system_sys_pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(LT),
    .LOCK_STABLE_CYCLES (LS),
    .MAX_RETRIES        (MR),
    .SYNC_STAGES        (SS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .sys_reset_n    (sys_reset_n),
    .fail           (fail),
    .state          (state),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [2:0] st;
    logic       rst;
    logic       srn;
    logic       fl;
    logic [7:0] retry;
    logic [7:0] loss;
  } obs_t;

  typedef enum {P_PULSE, P_WAIT, P_STAB, P_RUN, P_FAIL} phase_e;

  phase_e ph;
  int     pulse_edges, wait_edges, stable_edges, retries, losses;
  bit     hist[$];
  obs_t   exp_q[$];

  function automatic void model_reset();
    ph           = P_PULSE;
    pulse_edges  = 0;
    wait_edges   = 0;
    stable_edges = 0;
    retries      = 0;
    losses       = 0;
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(1'b0);
  endfunction

  // Decisions see the pll_locked sample taken SS edges earlier.
  function automatic void model_step(input bit sample);
    bit seen;
    seen = hist.pop_front();
    hist.push_back(sample);
    case (ph)
      P_PULSE: begin
        pulse_edges++;
        if (pulse_edges == RP) begin ph = P_WAIT; wait_edges = 0; end
      end
      P_WAIT: begin
        if (seen) begin
          ph = P_STAB; stable_edges = 0;
        end else begin
          wait_edges++;
          if (wait_edges == LT) begin
            if (retries == MR) ph = P_FAIL;
            else begin retries++; ph = P_PULSE; pulse_edges = 0; end
          end
        end
      end
      P_STAB: begin
        if (!seen) ph = P_WAIT;
        else begin
          stable_edges++;
          if (stable_edges == LS) begin ph = P_RUN; retries = 0; end
        end
      end
      P_RUN: begin
        if (!seen) begin
          ph = P_PULSE; pulse_edges = 0;
          losses = (losses >= 255) ? 255 : losses + 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic obs_t model_view();
    obs_t o;
    case (ph)
      P_PULSE: o.st = 3'd0;
      P_WAIT:  o.st = 3'd1;
      P_STAB:  o.st = 3'd2;
      P_RUN:   o.st = 3'd3;
      default: o.st = 3'd4;
    endcase
    o.rst   = (ph == P_PULSE) || (ph == P_FAIL);
    o.srn   = (ph == P_RUN);
    o.fl    = (ph == P_FAIL);
    o.retry = 8'(retries);
    o.loss  = 8'(losses);
    return o;
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (!reset_n) model_reset();
    else model_step(pll_locked);
    exp_q.push_back(model_view());
  end

  // ---------------- monitor ----------------
  obs_t mon_exp, mon_got;

  always @(posedge clk) begin
    #1;
    mon_got = '{st: state, rst: pll_rst, srn: sys_reset_n, fl: fail,
                retry: retry_count, loss: lock_loss_count};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty at t=%0t", $time);
    end else begin
      mon_exp = exp_q.pop_front();
      if (mon_got === mon_exp) n_pass++;
      else $display("FAIL cycle t=%0t got st=%0d rst=%b srn=%b fail=%b retry=%0d loss=%0d exp st=%0d rst=%b srn=%b fail=%b retry=%0d loss=%0d",
                    $time, mon_got.st, mon_got.rst, mon_got.srn, mon_got.fl, mon_got.retry, mon_got.loss,
                    mon_exp.st, mon_exp.rst, mon_exp.srn, mon_exp.fl, mon_exp.retry, mon_exp.loss);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_for(input int cond, input int max_edges, output int edges);
    bit hit;
    edges = 0;
    hit   = 1'b0;
    while (!hit && edges < max_edges) begin
      @(posedge clk);
      #1;
      edges++;
      case (cond)
        C_RST_LOW:  hit = (pll_rst == 1'b0);
        C_RST_HIGH: hit = (pll_rst == 1'b1);
        C_SRN_HIGH: hit = (sys_reset_n == 1'b1);
        C_SRN_LOW:  hit = (sys_reset_n == 1'b0);
        C_STAB:     hit = (state == 3'd2);
        C_FAIL:     hit = (state == 3'd4);
        default:    hit = 1'b1;
      endcase
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL wait_timeout cond=%0d got=%0d edges exp=<%0d", cond, edges, max_edges);
    end
  endtask

  task automatic do_reset(input logic lk);
    @(negedge clk);
    reset_n    = 1'b0;
    pll_locked = lk;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int n, bad;
    bit lvl;
    int len;

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);
    #1;
    check("reset_state",      32'(state), 0);
    check("reset_pll_rst",    32'(pll_rst), 1);
    check("reset_sys_reset_n",32'(sys_reset_n), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Clean bring-up
    wait_for(C_RST_LOW, 50, n);
    check("bringup_pulse_len", 32'(n), RP);
    repeat (6) @(negedge clk);
    pll_locked = 1'b1;
    wait_for(C_SRN_HIGH, 100, n);
    check("bringup_release_latency", 32'(n), SS + 1 + LS);
    check("bringup_state", 32'(state), 3);
    check("bringup_retry", 32'(retry_count), 0);

    // Retry then lock
    do_reset(1'b0);
    wait_for(C_RST_LOW, 50, n);
    check("retry_first_pulse", 32'(n), RP);
    wait_for(C_RST_HIGH, 100, n);
    check("retry_timeout_len", 32'(n), LT);
    check("retry_count_1", 32'(retry_count), 1);
    wait_for(C_RST_LOW, 50, n);
    check("retry_second_pulse", 32'(n), RP);
    @(negedge clk);
    pll_locked = 1'b1;
    wait_for(C_STAB, 50, n);
    check("retry_to_stab", 32'(n), SS + 1);
    check("retry_count_in_stab", 32'(retry_count), 1);
    wait_for(C_SRN_HIGH, 50, n);
    check("retry_stab_len", 32'(n), LS);
    check("retry_cleared_in_run", 32'(retry_count), 0);

    // Never locks
    do_reset(1'b0);
    wait_for(C_FAIL, 300, n);
    check("fail_after_attempts", 32'(n), (MR + 1) * (RP + LT));
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 50) begin @(negedge clk); pll_locked = 1'b1; end
      @(posedge clk);
      #1;
      if (!(state == 3'd4 && fail && pll_rst && !sys_reset_n)) bad++;
    end
    check("fail_held_bad_cycles", 32'(bad), 0);
    check("fail_retry_count", 32'(retry_count), MR);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("fail_clear_state", 32'(state), 0);
    check("fail_clear_fail", 32'(fail), 0);
    check("fail_clear_retry", 32'(retry_count), 0);
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    reset_n    = 1'b1;

    // Flaky stabilize
    do_reset(1'b1);
    wait_for(C_STAB, 50, n);
    check("flaky_first_stab", 32'(n), RP + 1);
    repeat (4) @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("flaky_back_to_wait", 32'(state), 1);
    check("flaky_no_pulse", 32'(pll_rst), 0);
    pll_locked = 1'b1;
    wait_for(C_STAB, 50, n);
    check("flaky_relock", 32'(n), SS + 1);
    wait_for(C_SRN_HIGH, 50, n);
    check("flaky_run_after", 32'(n), LS);

    // Loss in RUN
    @(negedge clk);
    pll_locked = 1'b0;
    wait_for(C_SRN_LOW, 20, n);
    check("loss_latency", 32'(n), SS + 1);
    check("loss_count_1", 32'(lock_loss_count), 1);
    check("loss_state", 32'(state), 0);
    check("loss_pll_rst", 32'(pll_rst), 1);
    wait_for(C_RST_LOW, 20, n);
    check("loss_pulse_len", 32'(n), RP);
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      pll_locked = 1'b1;
      wait_for(C_SRN_HIGH, 100, n);
      @(negedge clk);
      pll_locked = 1'b0;
      wait_for(C_SRN_LOW, 20, n);
    end
    check("loss_saturated", 32'(lock_loss_count), 255);

    // Async reset mid-STABILIZE
    @(negedge clk);
    pll_locked = 1'b1;
    wait_for(C_STAB, 100, n);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_pll_rst", 32'(pll_rst), 1);
    check("async_sys_reset_n", 32'(sys_reset_n), 0);
    check("async_fail", 32'(fail), 0);
    check("async_retry", 32'(retry_count), 0);
    check("async_loss", 32'(lock_loss_count), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Random lock traffic
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset_n = 1'b1;
      end
      lvl = ($urandom_range(0, 99) < 60);
      len = ($urandom_range(0, 9) == 0) ? 80 : int'($urandom_range(1, 40));
      @(negedge clk);
      pll_locked = lvl;
      repeat (len) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
